// File: rtl/uart_send.sv
// uart_send: 8N1 UART transmitter with a small transmit FIFO.
// Bytes are accepted over a valid/ready handshake, buffered, and sent
// LSB-first on uart_txd. Frames are sent back-to-back while the FIFO has data.
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   tx_data, tx_valid     byte to send and its valid strobe
//   tx_ready              FIFO not full (push happens on tx_valid && tx_ready)
//   uart_txd              registered serial line, idles high
//   tx_busy               frame in flight or FIFO non-empty
//   tx_done               one-cycle pulse at the end of each stop bit
//   fifo_count            FIFO occupancy, 0..FIFO_DEPTH
module uart_send #(
  parameter int unsigned CLK_FREQ   = 40_000_000,
  parameter int unsigned UART_BPS   = 384_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            bit_end;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (clk_cnt_q == BIT_LAST);

  assign uart_txd   = txd_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != IDLE) || !fifo_empty;

  // Frame sequencer; a pop loads the FIFO head straight into the shift register.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        clk_cnt_d = clk_cnt_q + 16'd1;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        clk_cnt_d = clk_cnt_q + 16'd1;
        if (bit_end) begin
          clk_cnt_d = '0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        clk_cnt_d = clk_cnt_q + 16'd1;
        if (bit_end) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level follows the next state so uart_txd changes on the same edge.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // State and control registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: self-checking bench for uart_send at default parameters.
// A line monitor decodes every frame from uart_txd cycle by cycle and flags any
// bit that is not held for exactly one bit period; decoded bytes and tx_done
// times are compared against the queue of bytes the bench pushed.
module tb_uart_send;

  localparam int BPS   = 40_000_000 / 384_000;
  localparam int FRAME = 10 * BPS;
  localparam int TMO   = 20000;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         bad;
  } frame_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;

  frame_t     rx_q [$];
  int         done_q [$];
  logic [7:0] exp_q [$];
  frame_t     mon_f;
  logic       mon_ref;

  uart_send dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  always #5 sys_clk = ~sys_clk;

  // cyc equals N after the N-th rising edge.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Line monitor: frame begins at the first low sample seen while idle.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (mon_en && uart_txd === 1'b0) begin
        mon_f.start = cyc;
        mon_f.bad   = 1'b0;
        mon_f.data  = 8'h00;
        mon_ref     = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge sys_clk);
          if (k % BPS == 0) begin
            mon_ref = uart_txd;
            if (k == 0 && uart_txd !== 1'b0) mon_f.bad = 1'b1;
            if (k == 9 * BPS && uart_txd !== 1'b1) mon_f.bad = 1'b1;
            if (k >= BPS && k < 9 * BPS) mon_f.data[k / BPS - 1] = uart_txd;
          end else if (uart_txd !== mon_ref) begin
            mon_f.bad = 1'b1;
          end
        end
        rx_q.push_back(mon_f);
      end
    end
  end

  // tx_done pulse recorder.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_done === 1'b1) done_q.push_back(cyc);
    end
  end

  // Drive one byte; returns the edge index at which it was accepted.
  task automatic push(input logic [7:0] b, output int edge_n);
    int w = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && w < TMO) begin
      @(negedge sys_clk);
      w++;
    end
    if (w >= TMO) begin
      checks++;
      failures++;
      $display("FAIL push_timeout byte=%02h tx_ready stuck low", b);
    end
    @(negedge sys_clk);
    edge_n = cyc;
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n);
    int w = 0;
    while (rx_q.size() < n && w < TMO) begin
      @(negedge sys_clk);
      w++;
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (tx_busy !== 1'b0 && w < TMO) begin
      @(negedge sys_clk);
      w++;
    end
    repeat (BPS) @(negedge sys_clk);
  endtask

  task automatic clear_queues();
    rx_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int e;
    int lows;
    mon_en = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({uart_txd, tx_ready, tx_busy, tx_done, fifo_count} !== 7'b1100_000) begin
      failures++;
      $display("FAIL reset_init got txd=%b rdy=%b busy=%b done=%b cnt=%0d want 1 1 0 0 0",
               uart_txd, tx_ready, tx_busy, tx_done, fifo_count);
    end
    sys_rst = 1'b0;
    push(8'hC3, e);
    push(8'h5A, e);
    push(8'h96, e);
    tx_valid = 1'b0;
    repeat (300) @(negedge sys_clk);
    checks++;
    if (tx_busy !== 1'b1 || fifo_count !== 3'd2) begin
      failures++;
      $display("FAIL midframe_state got busy=%b cnt=%0d want busy=1 cnt=2", tx_busy, fifo_count);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({uart_txd, tx_ready, tx_busy, tx_done, fifo_count} !== 7'b1100_000) begin
      failures++;
      $display("FAIL reset_midframe got txd=%b rdy=%b busy=%b done=%b cnt=%0d want 1 1 0 0 0",
               uart_txd, tx_ready, tx_busy, tx_done, fifo_count);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    lows = 0;
    repeat (3 * FRAME) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1 || tx_done !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard got active_cycles=%0d busy=%b want 0 0", lows, tx_busy);
    end
    clear_queues();
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int n;
    push(8'h55, n);
    tx_valid = 1'b0;
    wait_frames(1);
    checks++;
    if (rx_q.size() != 1 || done_q.size() != 1) begin
      failures++;
      $display("FAIL single_count got frames=%0d dones=%0d want 1 1", rx_q.size(), done_q.size());
    end else begin
      checks++;
      if (rx_q[0].start != n + 1) begin
        failures++;
        $display("FAIL single_latency got start=%0d want %0d", rx_q[0].start, n + 1);
      end
      checks++;
      if (rx_q[0].data !== 8'h55 || rx_q[0].bad) begin
        failures++;
        $display("FAIL single_data got %02h bad=%b want 55 bad=0", rx_q[0].data, rx_q[0].bad);
      end
      checks++;
      if (done_q[0] != n + 1 + FRAME) begin
        failures++;
        $display("FAIL single_done got %0d want %0d", done_q[0], n + 1 + FRAME);
      end
    end
    wait_idle();
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] want [2];
    want[0] = 8'hA3;
    want[1] = 8'h0F;
    push(want[0], n);
    push(want[1], n);
    tx_valid = 1'b0;
    wait_frames(2);
    checks++;
    if (rx_q.size() != 2 || done_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count got frames=%0d dones=%0d want 2 2", rx_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rx_q[i].data !== want[i] || rx_q[i].bad || done_q[i] != rx_q[i].start + FRAME) begin
          failures++;
          $display("FAIL b2b_frame%0d got %02h bad=%b done=%0d want %02h bad=0 done=%0d",
                   i, rx_q[i].data, rx_q[i].bad, done_q[i], want[i], rx_q[i].start + FRAME);
        end
      end
      checks++;
      if (rx_q[1].start - rx_q[0].start != FRAME) begin
        failures++;
        $display("FAIL b2b_gap got %0d want %0d", rx_q[1].start - rx_q[0].start, FRAME);
      end
    end
    wait_idle();
    clear_queues();
  endtask

  task automatic test_fifo_full();
    int n;
    int first;
    for (int b = 1; b <= 5; b++) begin
      push(8'(b), n);
      if (b == 1) first = n;
    end
    checks++;
    if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_level got cnt=%0d rdy=%b want 4 0", fifo_count, tx_ready);
    end
    push(8'h06, n);
    tx_valid = 1'b0;
    // Sixth byte enters on the edge after the first stop-bit pop frees a slot.
    checks++;
    if (n != first + 1 + FRAME + 1) begin
      failures++;
      $display("FAIL full_accept_edge got %0d want %0d", n, first + 1 + FRAME + 1);
    end
    wait_frames(6);
    checks++;
    if (rx_q.size() != 6 || done_q.size() != 6) begin
      failures++;
      $display("FAIL full_count got frames=%0d dones=%0d want 6 6", rx_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_q[i].data !== exp_q[i] || rx_q[i].bad || rx_q[i].start != first + 1 + i * FRAME) begin
          failures++;
          $display("FAIL full_frame%0d got %02h bad=%b start=%0d want %02h bad=0 start=%0d",
                   i, rx_q[i].data, rx_q[i].bad, rx_q[i].start, exp_q[i], first + 1 + i * FRAME);
        end
      end
    end
    wait_idle();
    clear_queues();
  endtask

  task automatic test_simul_push_pop();
    int na;
    int nb;
    int nc;
    push(8'h3C, na);
    push(8'hE7, nb);
    tx_valid = 1'b0;
    // Line up the third push with the stop-bit pop of the first frame.
    while (cyc < na + FRAME) @(negedge sys_clk);
    push(8'h81, nc);
    tx_valid = 1'b0;
    checks++;
    if (nc != na + 1 + FRAME || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL simul_count got edge=%0d cnt=%0d want edge=%0d cnt=1",
               nc, fifo_count, na + 1 + FRAME);
    end
    wait_frames(3);
    checks++;
    if (rx_q.size() != 3 || done_q.size() != 3) begin
      failures++;
      $display("FAIL simul_frames got frames=%0d dones=%0d want 3 3", rx_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i].data !== exp_q[i] || rx_q[i].bad) begin
          failures++;
          $display("FAIL simul_frame%0d got %02h bad=%b want %02h", i, rx_q[i].data, rx_q[i].bad, exp_q[i]);
        end
      end
    end
    wait_idle();
    clear_queues();
  endtask

  task automatic test_loopback();
    int n;
    logic [7:0] pat [4];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h80;
    pat[3] = 8'h01;
    for (int i = 0; i < 4; i++) push(pat[i], n);
    tx_valid = 1'b0;
    wait_frames(4);
    checks++;
    if (rx_q.size() != 4 || done_q.size() != 4) begin
      failures++;
      $display("FAIL loop_count got frames=%0d dones=%0d want 4 4", rx_q.size(), done_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[i].data !== pat[i] || rx_q[i].bad || done_q[i] != rx_q[i].start + FRAME) begin
          failures++;
          $display("FAIL loop_frame%0d got %02h bad=%b done=%0d want %02h done=%0d",
                   i, rx_q[i].data, rx_q[i].bad, done_q[i], pat[i], rx_q[i].start + FRAME);
        end
      end
    end
    wait_idle();
    clear_queues();
  endtask

  task automatic test_random();
    int n;
    int nbytes;
    nbytes = 8;
    for (int i = 0; i < nbytes; i++) begin
      push(8'($urandom_range(0, 255)), n);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 1500)) @(negedge sys_clk);
    end
    wait_frames(nbytes);
    wait_idle();
    checks++;
    if (rx_q.size() != nbytes || done_q.size() != nbytes) begin
      failures++;
      $display("FAIL rand_count got frames=%0d dones=%0d want %0d", rx_q.size(), done_q.size(), nbytes);
    end else begin
      for (int i = 0; i < nbytes; i++) begin
        checks++;
        if (rx_q[i].data !== exp_q[i] || rx_q[i].bad || done_q[i] != rx_q[i].start + FRAME) begin
          failures++;
          $display("FAIL rand_frame%0d got %02h bad=%b want %02h", i, rx_q[i].data, rx_q[i].bad, exp_q[i]);
        end
      end
    end
    checks++;
    if (tx_busy !== 1'b0 || fifo_count !== 3'd0 || uart_txd !== 1'b1 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL rand_idle got busy=%b cnt=%0d txd=%b rdy=%b want 0 0 1 1",
               tx_busy, fifo_count, uart_txd, tx_ready);
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_simul_push_pop();
    test_loopback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
